// File: rtl/complex_solver_if.sv
// -----------------------------------------------------------------------------
// complex_solver_if
//
// Purpose:
//   Bundles the control handshake and the pair stream of complex_solver so the
//   solver and its driver/consumer connect through one port.
//
// Signals:
//   start      driver -> solver  Begin a search (honoured only while idle).
//   target     driver -> solver  Wanted tree output, latched with start.
//   out_ready  driver -> solver  Consumer accepts the pair on out_valid & out_ready.
//   busy       solver -> driver  High while a search is running or draining.
//   out_valid  solver -> driver  out_x/out_y hold a matching pair.
//   out_x      solver -> driver  Matching x operand (WIDTH bits).
//   out_y      solver -> driver  Matching y operand (WIDTH bits).
//   done       solver -> driver  One-cycle pulse at the end of a search.
//   match_cnt  solver -> driver  Accepted-pair count (2*WIDTH+1 bits), present
//                                only when COMPLEX_SOLVER_MATCH_CNT_EN is defined.
//
// Modports:
//   master  the side that starts searches and consumes pairs.
//   slave   the solver itself.
//
// Configuration macro: COMPLEX_SOLVER_MATCH_CNT_EN
// -----------------------------------------------------------------------------
interface complex_solver_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             target;
    logic             out_ready;
    logic             busy;
    logic             out_valid;
    logic [WIDTH-1:0] out_x;
    logic [WIDTH-1:0] out_y;
    logic             done;
`ifdef COMPLEX_SOLVER_MATCH_CNT_EN
    logic [2*WIDTH:0] match_cnt;

    modport master (
        output start, target, out_ready,
        input  busy, out_valid, out_x, out_y, done, match_cnt
    );

    modport slave (
        input  start, target, out_ready,
        output busy, out_valid, out_x, out_y, done, match_cnt
    );
`else
    modport master (
        output start, target, out_ready,
        input  busy, out_valid, out_x, out_y, done
    );

    modport slave (
        input  start, target, out_ready,
        output busy, out_valid, out_x, out_y, done
    );
`endif
endinterface

// File: rtl/complex_solver.sv
// -----------------------------------------------------------------------------
// complex_solver
//
// Purpose:
//   Sequential inverse of the AND-OR reduction tree
//     f = ((x0y0|x1y1)&(x2y2|x3y3)) | ((x4y4|x5y5)&(x6y6|x7y7))   (WIDTH = 8)
//   Generalised: level 1 is a bitwise AND of x and y, every following
//   pairwise level alternates OR, AND, OR, ... up to a single bit.
//   After a start it walks every (x,y) pair in ascending order of
//   idx = {x, y} and streams out each pair whose tree output equals the
//   latched target, one candidate evaluated per cycle, with valid/ready
//   back-pressure on the output.
//
// Parameters:
//   WIDTH   Operand width; power of two, >= 2. Search space is 2^(2*WIDTH).
//
// Ports:
//   clk     Clock, all logic on the rising edge.
//   rst     Synchronous reset, active-high. Aborts a running search without
//           issuing a done pulse.
//   bus     complex_solver_if.slave: start/target/out_ready in,
//           busy/out_valid/out_x/out_y/done (and match_cnt) out.
//
// Configuration macro:
//   COMPLEX_SOLVER_MATCH_CNT_EN  When defined, bus.match_cnt counts accepted
//                                pairs; cleared on start and reset, and holds
//                                its final value from done until the next start.
//                                When undefined, no counter exists.
//
// Timing:
//   start sampled in cycle 0 -> idx 0 evaluated in cycle 1 -> a matching pair
//   is visible on out_x/out_y in cycle 2. done is asserted in the last DRAIN
//   cycle, i.e. while busy is still high, so a start in that same cycle lands
//   outside IDLE and is ignored.
// -----------------------------------------------------------------------------
module complex_solver #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    complex_solver_if.slave bus
);

    localparam int IDX_W  = 2 * WIDTH;
    localparam int LEVELS = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [IDX_W-1:0] idx;
    logic             target_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic             valid_q;

    logic [WIDTH-1:0] cur_x;
    logic [WIDTH-1:0] cur_y;
    logic             tree_out;
    logic             match;
    logic             last_idx;
    logic             stall;

    // FSM decode results
    logic             busy;
    logic             done;
    logic             load_start;
    logic             eval_en;

    assign cur_x    = idx[IDX_W-1:WIDTH];
    assign cur_y    = idx[WIDTH-1:0];
    assign last_idx = &idx;

    // A held pair that the consumer has not taken freezes the walk.
    assign stall = valid_q & ~bus.out_ready;

    // -------------------------------------------------------------------------
    // Reduction tree. Level 0 is the bitwise AND of the operands; level l
    // halves the vector, combining neighbours with OR on odd levels and AND
    // on even levels. Each level is sized exactly so every bit is used.
    // -------------------------------------------------------------------------
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        logic [(WIDTH >> l) - 1:0] v;

        if (l == 0) begin : g_leaf
            assign v = cur_x & cur_y;
        end else begin : g_pair
            for (genvar i = 0; i < (WIDTH >> l); i++) begin : g_node
                if ((l % 2) == 1) begin : g_or
                    assign v[i] = g_lvl[l-1].v[2*i] | g_lvl[l-1].v[2*i+1];
                end else begin : g_and
                    assign v[i] = g_lvl[l-1].v[2*i] & g_lvl[l-1].v[2*i+1];
                end
            end
        end
    end

    assign tree_out = g_lvl[LEVELS].v[0];
    assign match    = (tree_out == target_q);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and control decode
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        load_start = 1'b0;
        eval_en    = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    load_start = 1'b1;
                    state_next = RUN;
                end
            end

            RUN: begin
                busy = 1'b1;
                if (!stall) begin
                    eval_en = 1'b1;
                    // The final index is evaluated here; no wrap afterwards.
                    if (last_idx) begin
                        state_next = DRAIN;
                    end
                end
            end

            DRAIN: begin
                busy = 1'b1;
                // Finish once nothing is pending or the pending pair is being
                // taken this cycle. A reset in this cycle wins: no done pulse.
                if (!rst && (!valid_q || bus.out_ready)) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Search datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            target_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (load_start) begin
                target_q <= bus.target;
                idx      <= '0;
            end

            if (eval_en) begin
                if (match) begin
                    // Only a new match updates the visible operands.
                    x_q     <= cur_x;
                    y_q     <= cur_y;
                    valid_q <= 1'b1;
                end else begin
                    // Any pending pair was consumed this cycle (not stalled).
                    valid_q <= 1'b0;
                end

                if (!last_idx) begin
                    idx <= idx + IDX_W'(1);
                end
            end

            if (done) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef COMPLEX_SOLVER_MATCH_CNT_EN
    // -------------------------------------------------------------------------
    // Accepted-pair counter. One bit wider than idx so a search where every
    // pair matches (2^(2*WIDTH) pairs) still fits.
    // -------------------------------------------------------------------------
    logic [IDX_W:0] match_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt_q <= '0;
        end else if (load_start) begin
            match_cnt_q <= '0;
        end else if (valid_q && bus.out_ready) begin
            match_cnt_q <= match_cnt_q + (IDX_W + 1)'(1);
        end
    end

    assign bus.match_cnt = match_cnt_q;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.out_valid = valid_q;
    assign bus.out_x     = x_q;
    assign bus.out_y     = y_q;

endmodule
